// File: rtl/led_panel_pkg.sv
// Shared LED panel geometry, frame loader state encoding and default start-of-frame marker.
package led_panel_pkg;

   localparam int PANEL_COLS = 16;
   localparam int PANEL_ROWS = 8;
   localparam int COL_W      = $clog2(PANEL_COLS);

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_CHECK,
      S_PENDING
   } loader_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/frame_buffer_2x.sv
// Double-buffered 16x8 panel image: writes land in the back buffer, reads come from the front,
// and a swap strobe exchanges the two roles.
module frame_buffer_2x
   import led_panel_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [COL_W-1:0]      wr_addr,
   input  logic [PANEL_ROWS-1:0] wr_data,
   input  logic                  swap,
   input  logic [COL_W-1:0]      rd_addr,
   output logic [PANEL_ROWS-1:0] rd_data
);

   logic [PANEL_ROWS-1:0] mem_q [2][PANEL_COLS];
   logic                  front_q;

   // NOTE: the storage is small enough to clear in reset, which keeps a blank panel
   // after power-up instead of whatever the flops wake up holding.
   always_ff @(posedge clk) begin
      if (reset) begin
         front_q <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < PANEL_COLS; c++) begin
               mem_q[b][c] <= '0;
            end
         end
      end else begin
         if (wr_en) begin
            mem_q[~front_q][wr_addr] <= wr_data;
         end
         if (swap) begin
            front_q <= ~front_q;
         end
      end
   end

   assign rd_data = mem_q[front_q][rd_addr];

endmodule

// File: rtl/frame_loader.sv
// UART frame loader: SYNC_BYTE + 16 column bytes (+ XOR checksum when FRAME_LOADER_CHECKSUM_EN
// is defined) fill the back buffer, which becomes visible at the next panel frame_sync.
module frame_loader
   import led_panel_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   input  logic                  frame_sync,
   input  logic [COL_W-1:0]      rd_col,
   output logic [PANEL_ROWS-1:0] rd_data,
   output logic                  frame_ok,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int GAP_W = max_int(17, $clog2(TIMEOUT_CYCLES + 1));

   loader_state_e    state_q;
   logic [COL_W-1:0] index_q;
   logic [GAP_W-1:0] gap_q;
   logic             frame_ok_q;
   logic             frame_err_q;
`ifdef FRAME_LOADER_CHECKSUM_EN
   logic [7:0]       chk_q;
`endif

   logic wr_en;
   logic swap;
   logic gap_expired;

   assign wr_en       = (state_q == S_DATA) && rx_valid;
   assign swap        = (state_q == S_PENDING) && frame_sync;
   assign gap_expired = (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         gap_q       <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
         chk_q       <= '0;
`endif
      end else begin
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                  state_q <= S_DATA;
                  index_q <= '0;
                  gap_q   <= '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
                  chk_q   <= '0;
`endif
               end
            end
            S_DATA: begin
               if (rx_valid) begin
                  gap_q   <= '0;
                  index_q <= index_q + 1'b1;
`ifdef FRAME_LOADER_CHECKSUM_EN
                  chk_q   <= chk_q ^ rx_byte;
                  if (index_q == COL_W'(PANEL_COLS - 1)) begin
                     state_q <= S_CHECK;
                  end
`else
                  if (index_q == COL_W'(PANEL_COLS - 1)) begin
                     state_q    <= S_PENDING;
                     frame_ok_q <= 1'b1;
                  end
`endif
               end else if (gap_expired) begin
                  state_q     <= S_IDLE;
                  frame_err_q <= 1'b1;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
`ifdef FRAME_LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (rx_valid) begin
                  gap_q <= '0;
                  if (rx_byte == chk_q) begin
                     state_q    <= S_PENDING;
                     frame_ok_q <= 1'b1;
                  end else begin
                     state_q     <= S_IDLE;
                     frame_err_q <= 1'b1;
                  end
               end else if (gap_expired) begin
                  state_q     <= S_IDLE;
                  frame_err_q <= 1'b1;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
`endif
            S_PENDING: begin
               // The loaded image waits for the panel; any byte now would overwrite it, so it is dropped.
               if (rx_valid) begin
                  frame_err_q <= 1'b1;
               end
               if (frame_sync) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   frame_buffer_2x u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (index_q),
      .wr_data (rx_byte),
      .swap    (swap),
      .rd_addr (rd_col),
      .rd_data (rd_data)
   );

   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != S_IDLE);

endmodule
